// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between fifo_burst_reader, the FIFO read port and the downstream stream sink.
// master is the reader's view; slave is the view of whatever drives requests, the FIFO and the sink.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic                  busy;
    logic [LEN_WIDTH-1:0]  words_left;
    logic                  done;
    logic                  timeout;

    modport master (
        input  start, burst_len, fifo_rd_data, fifo_empty, m_ready,
        output fifo_rd, m_valid, m_data, m_last, busy, words_left, done, timeout
    );

    modport slave (
        output start, burst_len, fifo_rd_data, fifo_empty, m_ready,
        input  fifo_rd, m_valid, m_data, m_last, busy, words_left, done, timeout
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a burst of words from a first-word-fall-through FIFO onto a registered valid/ready stream.
// Define BURST_TIMEOUT_EN to abort a burst after TIMEOUT_CYCLES consecutive empty-FIFO cycles.
module fifo_burst_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                arst_n,
    fifo_burst_reader_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || LEN_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_params
        $error("fifo_burst_reader: parameters must be positive");
    end

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  done_q;
    logic                  done_next;
    logic [LEN_WIDTH-1:0]  left_q;
    logic                  pop;
    logic                  handshake;
    logic                  accept;

`ifdef BURST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] empty_cnt;
    logic             timed_out_q;
    logic             timeout_q;
    logic             timeout_next;
    logic             force_last;
    logic             expire;

    assign expire = (state == READ) && bus.fifo_empty && (left_q != '0) &&
                    (empty_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign accept    = bus.start && (bus.burst_len != '0);
    assign handshake = valid_q && bus.m_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pop is only allowed when the output register is empty or being emptied this cycle.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done_next  = 1'b0;
`ifdef BURST_TIMEOUT_EN
        timeout_next = 1'b0;
        force_last   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = READ;
                end
            end
            READ: begin
                pop = (left_q != '0) && !bus.fifo_empty && (!valid_q || bus.m_ready);
                if (pop && (left_q == LEN_WIDTH'(1))) begin
                    state_next = DRAIN;
                end
`ifdef BURST_TIMEOUT_EN
                else if (expire) begin
                    if (valid_q && !bus.m_ready) begin
                        force_last = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        state_next   = IDLE;
                        done_next    = 1'b1;
                        timeout_next = 1'b1;
                    end
                end
`endif
            end
            DRAIN: begin
                if (handshake && last_q) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
`ifdef BURST_TIMEOUT_EN
                    timeout_next = timed_out_q;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            left_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_next;
            if ((state == IDLE) && accept) begin
                left_q <= bus.burst_len;
            end
            if (pop) begin
                data_q  <= bus.fifo_rd_data;
                valid_q <= 1'b1;
                last_q  <= (left_q == LEN_WIDTH'(1));
                left_q  <= left_q - LEN_WIDTH'(1);
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
`ifdef BURST_TIMEOUT_EN
            if (force_last) begin
                last_q <= 1'b1;
            end
`endif
        end
    end

`ifdef BURST_TIMEOUT_EN
    // Any cycle that is not a starved READ cycle breaks the run of empty cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            empty_cnt   <= '0;
            timed_out_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= timeout_next;
            if ((state == READ) && !pop && bus.fifo_empty && (left_q != '0)) begin
                empty_cnt <= empty_cnt + CNT_W'(1);
            end else begin
                empty_cnt <= '0;
            end
            if (state == IDLE) begin
                timed_out_q <= 1'b0;
            end else if (force_last) begin
                timed_out_q <= 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.fifo_rd    = pop;
    assign bus.m_valid    = valid_q;
    assign bus.m_data     = data_q;
    assign bus.m_last     = last_q;
    assign bus.busy       = (state != IDLE);
    assign bus.words_left = left_q;
    assign bus.done       = done_q;

endmodule
